// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver.
//   - 2-flop synchroniser on rx_line, majority vote of three mid-bit samples.
//   - DATA_BITS 5..9 (LSB first), PARITY 0=none/1=odd/2=even, STOP_BITS 1..2.
//   - Frame completes at the decision tick of the last stop bit, half a bit
//     early, so a back-to-back start bit can be picked up cleanly.
//   - Optional feature macro: UART_RX_BREAK_DET_EN (line-break detection with
//     a BREAK state). When undefined, break_det is tied low.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] TC_S0   = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_S1   = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] TC_S2   = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`endif

    state_t                 state_reg;
    logic [1:0]             sync_reg;
    logic [TCW-1:0]         tc_reg;
    logic [3:0]             bit_cnt_reg;
    logic                   s0_reg;
    logic                   s1_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit_reg;
    logic                   fe_acc_reg;
    logic                   armed_reg;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   valid_reg;
    logic                   pe_reg;
    logic                   fe_reg;
    logic                   busy_reg;

    logic rs;
    logic vote;
    logic par_x;
    logic pe_now;
    logic fe_now;

    assign rs     = sync_reg[1];
    // Third sample is the live synchronised line at the decision tick.
    assign vote   = (s0_reg & s1_reg) | (s0_reg & rs) | (s1_reg & rs);
    assign par_x  = (^shift_reg) ^ par_bit_reg;
    assign pe_now = (PARITY == 1) ? ~par_x : ((PARITY == 2) ? par_x : 1'b0);
    // Includes the stop bit being decided right now.
    assign fe_now = fe_acc_reg | ~vote;

`ifdef UART_RX_BREAK_DET_EN
    logic brk_reg;
    logic brk_cond;
    assign brk_cond  = fe_now && (shift_reg == '0) && !par_bit_reg;
    assign break_det = brk_reg;
`else
    assign break_det = 1'b0;
`endif

    assign data_out   = data_reg;
    assign valid      = valid_reg;
    assign parity_err = pe_reg;
    assign frame_err  = fe_reg;
    assign busy       = busy_reg;

    // Two-flop synchroniser for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_line};
        end
    end

    // Receive FSM: tick counting, sampling, voting, shifting and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            tc_reg      <= '0;
            bit_cnt_reg <= '0;
            s0_reg      <= 1'b1;
            s1_reg      <= 1'b1;
            shift_reg   <= '0;
            par_bit_reg <= 1'b0;
            fe_acc_reg  <= 1'b0;
            armed_reg   <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            pe_reg      <= 1'b0;
            fe_reg      <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_reg     <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            pe_reg    <= 1'b0;
            fe_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_reg   <= 1'b0;
`endif
            if (os_tick) begin
                case (state_reg)
                    S_IDLE: begin
                        // After reset, only a genuine falling edge may start a frame.
                        if (rs) begin
                            armed_reg <= 1'b1;
                        end else if (armed_reg) begin
                            state_reg   <= S_START;
                            tc_reg      <= TCW'(1);
                            bit_cnt_reg <= '0;
                            par_bit_reg <= 1'b0;
                            fe_acc_reg  <= 1'b0;
                            busy_reg    <= 1'b1;
                        end
                    end
`ifdef UART_RX_BREAK_DET_EN
                    S_BREAK: begin
                        if (rs) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        tc_reg <= (tc_reg == TC_LAST) ? '0 : tc_reg + 1'b1;
                        if (tc_reg == TC_S0) s0_reg <= rs;
                        if (tc_reg == TC_S1) s1_reg <= rs;
                        if (tc_reg == TC_S2) begin
                            case (state_reg)
                                S_START: begin
                                    if (vote) begin
                                        state_reg <= S_IDLE;
                                        tc_reg    <= '0;
                                        busy_reg  <= 1'b0;
                                    end else begin
                                        state_reg <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                                    if (bit_cnt_reg == LAST_DATA) begin
                                        bit_cnt_reg <= '0;
                                        state_reg   <= (PARITY != 0) ? S_PARITY : S_STOP;
                                    end else begin
                                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                                    end
                                end
                                S_PARITY: begin
                                    par_bit_reg <= vote;
                                    state_reg   <= S_STOP;
                                end
                                S_STOP: begin
                                    if (!vote) fe_acc_reg <= 1'b1;
                                    if (bit_cnt_reg == LAST_STOP) begin
                                        // Finish half a bit early to catch a back-to-back start.
                                        state_reg   <= S_IDLE;
                                        tc_reg      <= '0;
                                        bit_cnt_reg <= '0;
                                        busy_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                                        if (brk_cond) begin
                                            brk_reg   <= 1'b1;
                                            state_reg <= S_BREAK;
                                            busy_reg  <= 1'b1;
                                        end else begin
                                            valid_reg <= 1'b1;
                                            data_reg  <= shift_reg;
                                            pe_reg    <= pe_now;
                                            fe_reg    <= fe_now;
                                        end
`else
                                        valid_reg <= 1'b1;
                                        data_reg  <= shift_reg;
                                        pe_reg    <= pe_now;
                                        fe_reg    <= fe_now;
`endif
                                    end else begin
                                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + randomised frames for three receiver configurations
// (8N1 default, 7 bits even parity, 8 bits 2 stop bits). Expected results come
// from a frame builder/decoder that applies the UART framing rules directly.
module tb_uart_rx_os;
    localparam int OS   = 16;
    localparam int TICK = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic os_tick = 1'b0;
    int   tick_cnt = 0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;

    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic v0, pe0, fe0, bk0, by0;
    logic v1, pe1, fe1, bk1, by1;
    logic v2, pe2, fe2, bk2, by2;

    int checks = 0;
    int errors = 0;
    int vcnt [3] = '{0, 0, 0};
    int bcnt [3] = '{0, 0, 0};
    logic [8:0] ld [3];
    logic lpe [3];
    logic lfe [3];
    logic [8:0] last_exp [3];

    uart_rx_os u0 (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(rx0),
        .data_out(d0), .valid(v0), .parity_err(pe0), .frame_err(fe0),
        .break_det(bk0), .busy(by0));

    uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(rx1),
        .data_out(d1), .valid(v1), .parity_err(pe1), .frame_err(fe1),
        .break_det(bk1), .busy(by1));

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .os_tick(os_tick), .rx_line(rx2),
        .data_out(d2), .valid(v2), .parity_err(pe2), .frame_err(fe2),
        .break_det(bk2), .busy(by2));

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Oversample tick: one clk wide, every TICK clocks, free-running through reset.
    always @(posedge clk) begin
        if (tick_cnt == TICK - 1) begin
            tick_cnt <= 0;
            os_tick  <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            os_tick  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture every result pulse; busy must be low whenever valid pulses.
    always @(negedge clk) begin
        if (v0) begin
            vcnt[0]++; ld[0] = 9'(d0); lpe[0] = pe0; lfe[0] = fe0;
            check("busy_on_valid_u0", 32'(by0), 32'd0);
        end
        if (v1) begin
            vcnt[1]++; ld[1] = 9'(d1); lpe[1] = pe1; lfe[1] = fe1;
            check("busy_on_valid_u1", 32'(by1), 32'd0);
        end
        if (v2) begin
            vcnt[2]++; ld[2] = 9'(d2); lpe[2] = pe2; lfe[2] = fe2;
            check("busy_on_valid_u2", 32'(by2), 32'd0);
        end
        if (bk0) bcnt[0]++;
        if (bk1) bcnt[1]++;
        if (bk2) bcnt[2]++;
    end

    task automatic wait_tick();
        do @(negedge clk); while (os_tick !== 1'b1);
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic hold(input int idx, input logic v, input int nticks);
        for (int t = 0; t < nticks; t++) begin
            wait_tick();
            drive(idx, v);
        end
    endtask

    // Each frame bit lasts OS ticks; gbit selects a bit whose middle sample is inverted.
    task automatic send(input int idx, input logic [15:0] bits, input int n, input int gbit);
        logic v;
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < OS; t++) begin
                wait_tick();
                v = bits[b];
                if (b == gbit && t == OS / 2) v = ~v;
                drive(idx, v);
            end
        end
    endtask

    // Frame builder: start, data LSB first, optional parity, stop bits from stop_v.
    function automatic void build(input logic [8:0] data, input int nd, input int par,
                                  input int ns, input bit flip_par, input logic [1:0] stop_v,
                                  output logic [15:0] bits, output int n);
        logic x;
        bits = '0;
        n = 1;
        x = 1'b0;
        for (int i = 0; i < nd; i++) begin
            bits[n] = data[i];
            x = x ^ data[i];
            n++;
        end
        if (par != 0) begin
            bits[n] = x ^ (par == 1) ^ flip_par;
            n++;
        end
        for (int s = 0; s < ns; s++) begin
            bits[n] = stop_v[s];
            n++;
        end
    endfunction

    // Frame decoder: what a receiver must report for a given bit sequence.
    function automatic void decode(input logic [15:0] bits, input int nd, input int par,
                                   input int ns, output logic [8:0] d, output logic pe,
                                   output logic fe);
        logic x;
        d = '0;
        x = 1'b0;
        for (int i = 0; i < nd; i++) begin
            d[i] = bits[1 + i];
            x = x ^ bits[1 + i];
        end
        pe = (par != 0) ? ((x ^ bits[1 + nd]) ^ (par == 1)) : 1'b0;
        fe = 1'b0;
        for (int s = 0; s < ns; s++)
            if (bits[1 + nd + (par != 0) + s] == 1'b0) fe = 1'b1;
    endfunction

    task automatic check_frame(input string tag, input int idx, input int exp_cnt,
                               input logic [8:0] exp_d, input logic exp_pe, input logic exp_fe);
        int guard;
        guard = 0;
        while (vcnt[idx] < exp_cnt && guard < 2 * OS * TICK) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_count"}, 32'(vcnt[idx]), 32'(exp_cnt));
        check({tag, "_data"},  32'(ld[idx]),   32'(exp_d));
        check({tag, "_perr"},  32'(lpe[idx]),  32'(exp_pe));
        check({tag, "_ferr"},  32'(lfe[idx]),  32'(exp_fe));
        $display("frame %s: u%0d data=%0h perr=%0b ferr=%0b (expected %0h/%0b/%0b)",
                 tag, idx, ld[idx], lpe[idx], lfe[idx], exp_d, exp_pe, exp_fe);
    endtask

    task automatic tx_and_check(input string tag, input int idx, input logic [8:0] data,
                                input int nd, input int par, input int ns, input bit flip,
                                input logic [1:0] stop_v, input int gbit, input int idle);
        logic [15:0] bits;
        int n;
        int exp_cnt;
        logic [8:0] ed;
        logic epe, efe;
        build(data, nd, par, ns, flip, stop_v, bits, n);
        decode(bits, nd, par, ns, ed, epe, efe);
        exp_cnt = vcnt[idx] + 1;
        send(idx, bits, n, gbit);
        hold(idx, 1'b1, idle);
        check_frame(tag, idx, exp_cnt, ed, epe, efe);
        last_exp[idx] = ed;
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int cb;
        logic [8:0] rd;
        logic [15:0] bits;
        int n;

        repeat (5) @(negedge clk);
        check("rst_data_u0",  32'(d0),  32'd0);
        check("rst_valid_u0", 32'(v0),  32'd0);
        check("rst_perr_u0",  32'(pe0), 32'd0);
        check("rst_ferr_u0",  32'(fe0), 32'd0);
        check("rst_break_u0", 32'(bk0), 32'd0);
        check("rst_busy_u0",  32'(by0), 32'd0);
        check("rst_busy_u1",  32'(by1), 32'd0);
        check("rst_busy_u2",  32'(by2), 32'd0);
        rst = 1'b0;
        hold(0, 1'b1, 4);

        fork
            begin
                tx_and_check("b3_clean",  0, 9'h0B3, 8, 0, 1, 1'b0, 2'b11, -1, 2);
                tx_and_check("b3_glitch", 0, 9'h0B3, 8, 0, 1, 1'b0, 2'b11, 4, 2);
                // Short low pulse: false start, busy briefly, no result.
                c = vcnt[0];
                hold(0, 1'b0, 4);
                check("false_start_busy_high", 32'(by0), 32'd1);
                hold(0, 1'b1, 8);
                check("false_start_busy_low", 32'(by0), 32'd0);
                hold(0, 1'b1, OS);
                check("false_start_no_valid", 32'(vcnt[0]), 32'(c));
                $display("false start: u0 busy=%0b valid_count=%0d", by0, vcnt[0]);
                for (int k = 0; k < 3; k++) begin
                    logic sb;
                    rd = 9'($urandom_range(0, 255));
                    sb = ($urandom_range(0, 3) != 0);
                    if (!sb) rd[0] = 1'b1;
                    tx_and_check("random", 0, rd, 8, 0, 1, 1'b0, {1'b1, sb},
                                 int'($urandom_range(0, 9)), OS);
                end
            end
            begin
                tx_and_check("p7_55_ok",  1, 9'h055, 7, 2, 1, 1'b0, 2'b11, -1, 2);
                tx_and_check("p7_55_bad", 1, 9'h055, 7, 2, 1, 1'b1, 2'b11, -1, 2);
            end
            begin
                tx_and_check("s2_a5_ferr", 2, 9'h0A5, 8, 0, 2, 1'b0, 2'b01, -1, 0);
                tx_and_check("s2_3c_b2b",  2, 9'h03C, 8, 0, 2, 1'b0, 2'b11, -1, 2);
            end
        join

        // Line break: low for 20 bit times, then idle, then a normal frame.
        c  = vcnt[0];
        cb = bcnt[0];
        hold(0, 1'b0, 10 * OS);
`ifdef UART_RX_BREAK_DET_EN
        check("break_pulse",    32'(bcnt[0]), 32'(cb + 1));
        check("break_no_valid", 32'(vcnt[0]), 32'(c));
        check("break_busy",     32'(by0),     32'd1);
`else
        check("break_as_valid_count", 32'(vcnt[0]), 32'(c + 1));
        check("break_as_valid_data",  32'(ld[0]),    32'd0);
        check("break_as_valid_ferr",  32'(lfe[0]),   32'd1);
`endif
        hold(0, 1'b0, 10 * OS);
        hold(0, 1'b1, OS);
        $display("break: u0 break_count=%0d valid_count=%0d", bcnt[0] - cb, vcnt[0] - c);
`ifdef UART_RX_BREAK_DET_EN
        check("break_single",    32'(bcnt[0]), 32'(cb + 1));
        check("break_data_held", 32'(d0),      32'(last_exp[0]));
        tx_and_check("after_break_3c", 0, 9'h03C, 8, 0, 1, 1'b0, 2'b11, -1, 2);
`else
        check("break_no_break_det", 32'(bcnt[0]), 32'(cb));
        hold(0, 1'b1, 12 * OS);
`endif

        // Reset in the middle of a frame.
        build(9'h0C9, 8, 0, 1, 1'b0, 2'b11, bits, n);
        send(0, bits, 4, -1);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data",  32'(d0),  32'd0);
        check("midrst_valid", 32'(v0),  32'd0);
        check("midrst_perr",  32'(pe0), 32'd0);
        check("midrst_ferr",  32'(fe0), 32'd0);
        check("midrst_break", 32'(bk0), 32'd0);
        check("midrst_busy",  32'(by0), 32'd0);
        c = vcnt[0];
        hold(0, 1'b1, 8 * OS);
        check("midrst_no_valid", 32'(vcnt[0]), 32'(c));
        $display("mid-frame reset: u0 valid_count_delta=%0d", vcnt[0] - c);
        tx_and_check("after_rst_7e", 0, 9'h07E, 8, 0, 1, 1'b0, 2'b11, -1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver that replaces the fixed 8N1 receiver in the serial path. It samples the line on a 16× (configurable) oversample tick and majority-votes each bit. It supports 5–9 data bits, optional parity and 1 or 2 stop bits, and reports framing and parity errors alongside each received word. It sits between the pad-side `rx_line` and the byte consumer, and is clocked by the same `baud_gen` instance (configured for `BAUD*OVERSAMPLE`).

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `OVERSAMPLE`, 16: `os_tick` pulses per bit period; even, ≥8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `os_tick`  in  1  one-`clk`-wide pulse at `OVERSAMPLE`×baud.
- `rx_line`  in  1  asynchronous serial input, idle high.
- `data_out`  out  DATA_BITS  last received word; holds until the next `valid`.
- `valid`  out  1  one-`clk` pulse when a frame completes.
- `parity_err`  out  1  pulses with `valid`; forced 0 when `PARITY`=0.
- `frame_err`  out  1  pulses with `valid`; at least one stop bit voted 0.
- `break_det`  out  1  one-`clk` pulse on line break (see Configuration).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx_line` passes through a 2-flop synchroniser (`rs`). Both flops reset to 1. All decisions use `rs`.
- Tick counter `tc` counts `os_tick` pulses 0..OVERSAMPLE-1 within a bit.
- Each bit is sampled on ticks `tc` = OS/2-1, OS/2 and OS/2+1. The bit value is the majority of the 3 samples, decided at `tc` = OS/2+1. At `tc` = OS-1 the counter wraps and the next bit begins.
- State machine: IDLE → START → DATA → PARITY → STOP → IDLE, plus BREAK when the macro is defined.
  - IDLE: on `os_tick` with `rs`=0, enter START with that tick counted as `tc`=0.
  - START: if the voted start bit is 1 (false start), return to IDLE at the decision tick. No outputs are produced.
  - DATA: shift voted bits LSB first, `DATA_BITS` bits in total.
  - PARITY: skipped when `PARITY`=0. Otherwise compute the error as XOR of the data bits and the parity bit, compared against the mode (odd expects XOR = 1, even expects XOR = 0).
  - STOP: `STOP_BITS` bits; any stop bit voted 0 sets the frame error.
- Frame completion: at the decision tick of the last stop bit, on the following `clk`:
  - `valid` pulses, `data_out` updates, and the error flags pulse.
  - The FSM returns to IDLE immediately, half a bit early, so it can resynchronise on a back-to-back start.
- An erroneous frame still updates `data_out` and pulses `valid`.
- `os_tick` arriving while `rst` is high is ignored.

## Timing
- Reset values: `data_out`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `break_det`=0, `busy`=0, state IDLE, `tc`=0, synchroniser = 1.
- Reset mid-frame abandons the frame with no output pulse. Reception resumes at the next falling edge after reset is released.
- Latency from the first tick seeing `rs`=0 to `valid`: `(1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)*OVERSAMPLE + OVERSAMPLE/2+1` ticks, then +1 `clk`. Add 2 `clk` for the synchroniser when measuring from `rx_line`.
- `busy` rises on the `clk` after the start-detect tick and falls together with the `valid` pulse.
- A glitch that affects one sample of any bit is rejected by the vote. A glitch of fewer than OS/2-1 ticks on an idle line causes a false start: `busy` is high for at most OS/2+2 ticks and there is no `valid`.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- Defined:
  - Break condition: frame error with all data bits 0 and the parity bit (if present) 0.
  - On break: `break_det` pulses instead of `valid`; no error flags pulse and `data_out` is unchanged.
  - The FSM enters BREAK and stays there, with `busy` high, until an `os_tick` sees `rs`=1. It then returns to IDLE.
- Not defined:
  - `break_det` is tied to 0 and there is no BREAK state.
  - A break is reported as `valid` with `data_out`=0 and `frame_err`=1.
  - The FSM returns to IDLE, where the still-low line starts a new frame at the next tick.

## Test plan
- 50 MHz `clk`, `os_tick` every 27 `clk`, defaults. Send 0xB3 → exactly one `valid` pulse, `data_out`=0xB3, `parity_err`=`frame_err`=0. Repeat with a one-tick inverted glitch on sample OS/2 of bit 3 → still 0xB3.
- Drive `rx_line` low for 4 ticks then high → no `valid`, `busy` back to 0 within OS/2+2 ticks.
- `DATA_BITS`=7, `PARITY`=2: send 0x55 with a correct parity bit → `parity_err`=0. Send 0x55 with the parity bit inverted → `valid`, `data_out`=0x55, `parity_err`=1.
- `STOP_BITS`=2: send 0xA5 with the second stop bit driven 0 → `valid`, `data_out`=0xA5, `frame_err`=1. Then send 0x3C back-to-back → clean 0x3C.
- Hold the line low for 20 bit times, then send 0x3C:
  - Macro defined → one `break_det` pulse, no `valid`, then 0x3C received cleanly.
  - Macro undefined → `valid` with 0x00 and `frame_err`=1.
- Assert `rst` for 1 `clk` after 3 data bits of 0xC9 → all outputs 0, no `valid` for 0xC9; the next frame 0x7E is received correctly.
